// File: rtl/gray_counter_src.sv
// Up/down binary counter with a registered Gray-code view and a valid/ready
// handshake; feeds a downstream Gray-to-binary converter.
module gray_counter_src #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] b,
  output logic             wrap,
  output logic             o_valid,
  input  logic             o_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  logic [WIDTH-1:0] cnt_p0;
  logic [WIDTH-1:0] gray_p0;
  logic             wrap_p0;
  state_t           state_p0;

  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_sum;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic             update;

  // Extra top bit carries out on increment and borrows on decrement; it is
  // only ever used to flag the boundary crossing.
  always_comb begin
    inc_sum   = {1'b0, cnt_p0} + {{WIDTH{1'b0}}, 1'b1};
    dec_sum   = {1'b0, cnt_p0} - {{WIDTH{1'b0}}, 1'b1};
    step_val  = up ? inc_sum[WIDTH-1:0] : dec_sum[WIDTH-1:0];
    step_wrap = up ? inc_sum[WIDTH] : dec_sum[WIDTH];
    update    = load | en;
  end

  // Stage p0: count, Gray view, wrap pulse and handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0   <= '0;
      gray_p0  <= '0;
      wrap_p0  <= 1'b0;
      state_p0 <= IDLE;
    end else begin
      if (load) begin
        cnt_p0  <= load_val;
        gray_p0 <= to_gray(load_val);
        wrap_p0 <= 1'b0;
      end else if (en) begin
        cnt_p0  <= step_val;
        gray_p0 <= to_gray(step_val);
        wrap_p0 <= step_wrap;
      end else begin
        wrap_p0 <= 1'b0;
      end

      // An unaccepted value is simply overwritten by a newer update.
      case (state_p0)
        IDLE:    if (update) state_p0 <= PEND;
        PEND:    if (o_ready && !update) state_p0 <= IDLE;
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign b       = cnt_p0;
  assign o       = gray_p0;
  assign wrap    = wrap_p0;
  assign o_valid = (state_p0 == PEND);

endmodule

// File: tb/tb_gray_counter_src.sv
// Self-checking bench for gray_counter_src: directed scenarios plus a long
// randomized run against an arithmetic reference model.
module tb_gray_counter_src;

  localparam int W = 32;
  localparam longint unsigned MODV = 64'd1 << W;
  localparam longint unsigned MAXV = MODV - 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] o;
  logic [W-1:0] b;
  logic         wrap;
  logic         o_valid;
  logic         o_ready;

  int checks;
  int errors;

  longint unsigned mb;
  logic            mvalid;
  logic            mwrap;
  logic [W-1:0]    prev_o;
  logic            was_step;

  gray_counter_src #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .o        (o),
    .b        (b),
    .wrap     (wrap),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray_of(input longint unsigned v);
    logic [W-1:0] x;
    x = v[W-1:0];
    return x ^ (x >> 1);
  endfunction

  // Downstream converter behaviour: binary bit i is the XOR of Gray bits i..top.
  function automatic logic [W-1:0] conv_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic tick(input logic r, input logic l, input logic [W-1:0] lv,
                      input logic e, input logic u, input logic rd);
    rst_n = r; load = l; load_val = lv; en = e; up = u; o_ready = rd;
    @(posedge clk);
    prev_o   = gray_of(mb);
    was_step = 1'b0;
    if (!r) begin
      mb = 0; mwrap = 1'b0; mvalid = 1'b0;
    end else if (l) begin
      mb = lv; mwrap = 1'b0; mvalid = 1'b1;
    end else if (e) begin
      was_step = 1'b1;
      mvalid   = 1'b1;
      if (u) begin
        mwrap = (mb == MAXV);
        mb    = (mb + 1) % MODV;
      end else begin
        mwrap = (mb == 0);
        mb    = (mb + MODV - 1) % MODV;
      end
    end else begin
      mwrap = 1'b0;
      if (mvalid && rd) mvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (b !== '0 || o !== '0 || wrap !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: b=%h o=%h wrap=%b vld=%b, want all 0", b, o, wrap, o_valid);
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] exp_o [4];
    exp_o = '{32'h1, 32'h3, 32'h2, 32'h6};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (b !== W'(i + 1) || o !== exp_o[i] || wrap !== 1'b0 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL count_up[%0d]: b=%h o=%h wrap=%b vld=%b, want b=%h o=%h wrap=0 vld=1",
                 i, b, o, wrap, o_valid, W'(i + 1), exp_o[i]);
      end
    end
  endtask

  task automatic test_wrap_up();
    tick(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    checks++;
    if (b !== 32'hFFFF_FFFF || o !== 32'h8000_0000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_max: b=%h o=%h wrap=%b, want ffffffff 80000000 0", b, o, wrap);
    end
    tick(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (b !== '0 || o !== '0 || wrap !== 1'b1 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: b=%h o=%h wrap=%b vld=%b, want 0 0 1 1", b, o, wrap, o_valid);
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (wrap !== 1'b0 || b !== '0) begin
      errors++;
      $display("FAIL wrap_pulse_len: wrap=%b b=%h, want wrap=0 b=0", wrap, b);
    end
  endtask

  task automatic test_wrap_down();
    tick(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b !== 32'hFFFF_FFFF || o !== 32'h8000_0000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: b=%h o=%h wrap=%b, want ffffffff 80000000 1", b, o, wrap);
    end
    tick(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (b !== 32'hFFFF_FFFE || o !== 32'h8000_0001 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_after_wrap: b=%h o=%h wrap=%b, want fffffffe 80000001 0", b, o, wrap);
    end
  endtask

  task automatic test_handshake();
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_drain: vld=%b, want 0", o_valid);
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_idle: vld=%b, want 0", o_valid);
    end
    tick(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("FAIL hs_hold[%0d]: vld=%b, want 1", i, o_valid);
      end
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_accept: vld=%b, want 0", o_valid);
    end
    tick(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (o_valid !== 1'b1 || o !== gray_of(mb) || b !== mb[W-1:0]) begin
      errors++;
      $display("FAIL hs_accept_update: vld=%b o=%h b=%h, want 1 %h %h",
               o_valid, o, b, gray_of(mb), mb[W-1:0]);
    end
  endtask

  task automatic test_priority();
    tick(1'b1, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
    checks++;
    if (b !== 32'h10 || o !== 32'h18 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_over_en: b=%h o=%h vld=%b, want 10 18 1", b, o, o_valid);
    end
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || b !== 32'h10) begin
      errors++;
      $display("FAIL load_same_value: vld=%b b=%h, want 1 10", o_valid, b);
    end
    tick(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    checks++;
    if (b !== '0 || o !== '0 || o_valid !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_load: b=%h o=%h vld=%b wrap=%b, want 0 0 0 0", b, o, o_valid, wrap);
    end
  endtask

  task automatic test_random();
    logic         r, l, e, u, rd;
    logic [W-1:0] lv;
    int           sel;
    int           bad;
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      r   = ($urandom_range(0, 499) != 0);
      l   = ($urandom_range(0, 15) == 0);
      e   = ($urandom_range(0, 3) != 0);
      u   = $urandom_range(0, 1);
      rd  = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       lv = W'($urandom_range(0, 3));
        1:       lv = 32'hFFFF_FFFF - W'($urandom_range(0, 3));
        2:       lv = 32'h8000_0000 ^ W'($urandom_range(0, 1));
        default: lv = $urandom;
      endcase
      tick(r, l, lv, e, u, rd);
      checks++;
      if (b !== mb[W-1:0] || o !== gray_of(mb) || wrap !== mwrap || o_valid !== mvalid) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_state[%0d]: b=%h o=%h wrap=%b vld=%b, want %h %h %b %b",
                   n, b, o, wrap, o_valid, mb[W-1:0], gray_of(mb), mwrap, mvalid);
        bad++;
      end
      checks++;
      if (conv_g2b(o) !== mb[W-1:0]) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_conv[%0d]: g2b(o)=%h, want %h", n, conv_g2b(o), mb[W-1:0]);
        bad++;
      end
      if (was_step) begin
        checks++;
        if ($countones(prev_o ^ o) != 1) begin
          errors++;
          if (bad < 10)
            $display("FAIL rand_single_step[%0d]: o %h -> %h changes %0d bits, want 1",
                     n, prev_o, o, $countones(prev_o ^ o));
          bad++;
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    mb = 0; mvalid = 1'b0; mwrap = 1'b0; prev_o = '0; was_step = 1'b0;
    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; o_ready = 1'b0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_handshake();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
